// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core pipeline.
// Flag layout, branch condition codes and datapath widths.
package core_pkg;

   localparam int DATA_W = 16;
   localparam int REG_AW = 3;
   localparam int CC_W   = 4;
   localparam int CNT_W  = 16;

   localparam int FLAG_S = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [2:0] BR_BE  = 3'd0;
   localparam logic [2:0] BR_BLT = 3'd1;
   localparam logic [2:0] BR_BLE = 3'd2;
   localparam logic [2:0] BR_BNE = 3'd3;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluation against SZCV flags.
// Codes 4-7 are reserved and never taken.
module br_cond_eval
   import core_pkg::*;
(
   input  logic [CC_W-1:0] flags,
   input  logic [2:0]      br_cond,
   output logic            taken
);

   logic lt;
   logic unused_c;

   assign lt       = flags[FLAG_S] ^ flags[FLAG_V];
   assign unused_c = flags[FLAG_C];

   // decode the condition code into a taken decision
   always_comb begin
      taken = 1'b0;
      case (br_cond)
         BR_BE:   taken = flags[FLAG_Z];
         BR_BLT:  taken = lt;
         BR_BLE:  taken = flags[FLAG_Z] | lt;
         BR_BNE:  taken = ~flags[FLAG_Z];
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute-to-writeback stage: one-entry result register,
// flag register, branch resolution and retire counter.
module ex_wb_stage
   import core_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [CC_W-1:0]   in_cond,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_wr_en,
   input  logic              in_set_cc,
   input  logic              in_is_branch,
   input  logic [2:0]        in_br_cond,
   input  logic [DATA_W-1:0] in_br_target,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic              wb_we,
   output logic [REG_AW-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [CC_W-1:0]   flags,
   output logic              br_taken,
   output logic [DATA_W-1:0] br_target,
   output logic [CNT_W-1:0]  retire_cnt
);

   logic accept;
   logic drain;
   logic cond_true;
   logic take;

   assign in_ready = !wb_valid || wb_ready;
   assign accept   = in_valid && in_ready;
   assign drain    = wb_valid && wb_ready;
   assign take     = accept && in_is_branch && cond_true;

   br_cond_eval u_br_cond_eval (
      .flags   (flags),
      .br_cond (in_br_cond),
      .taken   (cond_true)
   );

   // writeback entry: load on accept, empty on drain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid <= 1'b0;
         wb_we    <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
      end else if (accept) begin
         wb_valid <= 1'b1;
         wb_we    <= in_wr_en && !in_is_branch;
         wb_addr  <= in_rd;
         wb_data  <= in_result;
      end else if (drain) begin
         wb_valid <= 1'b0;
      end
   end

   // flags only change for accepted non-branch setters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags <= '0;
      end else if (accept && in_set_cc && !in_is_branch) begin
         flags <= in_cond;
      end
   end

   // single-cycle taken pulse with sticky target
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_taken  <= 1'b0;
         br_target <= '0;
      end else begin
         br_taken <= take;
         if (take) begin
            br_target <= in_br_target;
         end
      end
   end

   // count completed writeback handshakes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_cnt <= '0;
      end else if (drain) begin
         retire_cnt <= retire_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Randomized bench for ex_wb_stage with a behavioural model
// plus directed literal checks.
module tb_ex_wb_stage;
   import core_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_result = '0;
   logic [CC_W-1:0]   in_cond = '0;
   logic [REG_AW-1:0] in_rd = '0;
   logic              in_wr_en = 1'b0;
   logic              in_set_cc = 1'b0;
   logic              in_is_branch = 1'b0;
   logic [2:0]        in_br_cond = '0;
   logic [DATA_W-1:0] in_br_target = '0;
   logic              wb_valid;
   logic              wb_ready = 1'b1;
   logic              wb_we;
   logic [REG_AW-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [CC_W-1:0]   flags;
   logic              br_taken;
   logic [DATA_W-1:0] br_target;
   logic [CNT_W-1:0]  retire_cnt;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   // behavioural model state
   bit          m_valid;
   bit          m_we;
   int unsigned m_addr;
   int unsigned m_data;
   int unsigned m_flags;
   bit          m_br;
   int unsigned m_tgt;
   int unsigned m_cnt;

   ex_wb_stage dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_cond      (in_cond),
      .in_rd        (in_rd),
      .in_wr_en     (in_wr_en),
      .in_set_cc    (in_set_cc),
      .in_is_branch (in_is_branch),
      .in_br_cond   (in_br_cond),
      .in_br_target (in_br_target),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_we        (wb_we),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .flags        (flags),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .retire_cnt   (retire_cnt)
   );

   always #5 clk = ~clk;

   function automatic bit cond_holds(input int unsigned f,
                                     input int unsigned c);
      bit s, z, v;
      s = (f / 8) % 2 == 1;
      z = (f / 4) % 2 == 1;
      v = f % 2 == 1;
      if (c == 0) return z;
      if (c == 1) return s != v;
      if (c == 2) return z || (s != v);
      if (c == 3) return !z;
      return 1'b0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // model: what the stage must hold after each edge
   always @(posedge clk or posedge rst) begin
      bit acc, drn, tk;
      if (rst) begin
         m_valid = 0; m_we = 0; m_addr = 0; m_data = 0;
         m_flags = 0; m_br = 0; m_tgt = 0; m_cnt = 0;
      end else begin
         acc = in_valid && (!m_valid || wb_ready);
         drn = m_valid && wb_ready;
         tk  = acc && in_is_branch && cond_holds(m_flags, in_br_cond);
         if (drn) m_cnt = (m_cnt + 1) % 65536;
         m_br = tk;
         if (tk) m_tgt = in_br_target;
         if (acc && in_set_cc && !in_is_branch) m_flags = in_cond;
         if (acc) begin
            m_valid = 1;
            m_we    = in_wr_en && !in_is_branch;
            m_addr  = in_rd;
            m_data  = in_result;
         end else if (drn) begin
            m_valid = 0;
         end
      end
   end

   // compare DUT against model every cycle
   always @(negedge clk) begin
      if (chk_on) begin
         chk("in_ready", in_ready, !m_valid || wb_ready);
         chk("wb_valid", wb_valid, m_valid);
         chk("wb_we", wb_we, m_we);
         chk("wb_addr", wb_addr, m_addr);
         chk("wb_data", wb_data, m_data);
         chk("flags", flags, m_flags);
         chk("br_taken", br_taken, m_br);
         chk("br_target", br_target, m_tgt);
         chk("retire_cnt", retire_cnt, m_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] res, input logic [2:0] rd,
                       input logic wr, input logic scc,
                       input logic [3:0] cc, input logic br,
                       input logic [2:0] bc, input logic [15:0] tgt);
      in_result = res; in_rd = rd; in_wr_en = wr;
      in_set_cc = scc; in_cond = cc; in_is_branch = br;
      in_br_cond = bc; in_br_target = tgt;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      #1 chk_on = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst wb_valid", wb_valid, 0);
      chk("rst flags", flags, 0);
      chk("rst retire", retire_cnt, 0);
      chk("rst br_target", br_target, 0);

      // basic writeback
      send(16'h1234, 3'd5, 1, 0, 4'h0, 0, 3'd0, 16'h0);
      chk("wb1 valid", wb_valid, 1);
      chk("wb1 addr", wb_addr, 5);
      chk("wb1 data", wb_data, 16'h1234);
      chk("wb1 we", wb_we, 1);
      tick();
      chk("wb1 retire", retire_cnt, 1);

      // backpressure then no-bubble refill
      wb_ready = 1'b0;
      send(16'h00AA, 3'd1, 1, 0, 4'h0, 0, 3'd0, 16'h0);
      chk("bp data A", wb_data, 16'h00AA);
      chk("bp in_ready", in_ready, 0);
      in_result = 16'h00BB; in_valid = 1'b1;
      tick();
      chk("bp hold A", wb_data, 16'h00AA);
      wb_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("bp data B", wb_data, 16'h00BB);
      chk("bp valid B", wb_valid, 1);
      chk("bp retire", retire_cnt, 2);
      tick();

      // flags and BE
      send(16'h0, 3'd0, 0, 1, 4'b0100, 0, 3'd0, 16'h0);
      chk("flags Z", flags, 4'b0100);
      send(16'h0, 3'd0, 1, 0, 4'h0, 1, 3'd0, 16'h0040);
      chk("BE taken", br_taken, 1);
      chk("BE target", br_target, 16'h0040);
      chk("BE we", wb_we, 0);
      tick();
      chk("BE pulse end", br_taken, 0);

      // BLT / BLE / BNE / reserved
      send(16'h0, 3'd0, 0, 1, 4'b1000, 0, 3'd0, 16'h0);
      send(16'h0, 3'd0, 0, 0, 4'h0, 1, 3'd1, 16'h0050);
      chk("BLT S", br_taken, 1);
      send(16'h0, 3'd0, 0, 0, 4'h0, 1, 3'd2, 16'h0060);
      chk("BLE S", br_taken, 1);
      send(16'h0, 3'd0, 0, 1, 4'b1001, 0, 3'd0, 16'h0);
      send(16'h0, 3'd0, 0, 0, 4'h0, 1, 3'd1, 16'h0070);
      chk("BLT SV", br_taken, 0);
      send(16'h0, 3'd0, 0, 0, 4'h0, 1, 3'd2, 16'h0070);
      chk("BLE SV", br_taken, 0);
      send(16'h0, 3'd0, 0, 0, 4'h0, 1, 3'd3, 16'h0080);
      chk("BNE SV", br_taken, 1);
      chk("BNE target", br_target, 16'h0080);
      send(16'h0, 3'd0, 0, 0, 4'h0, 1, 3'd5, 16'h0090);
      chk("rsv cond", br_taken, 0);

      // flags immune to branches and stalled setters
      send(16'h0, 3'd0, 0, 1, 4'b1111, 1, 3'd6, 16'h0);
      chk("br set_cc", flags, 4'b1001);
      wb_ready = 1'b0;
      send(16'h0007, 3'd2, 1, 0, 4'h0, 0, 3'd0, 16'h0);
      in_set_cc = 1'b1; in_is_branch = 1'b0;
      in_cond = 4'b0010; in_valid = 1'b1;
      tick();
      tick();
      chk("stall flags", flags, 4'b1001);
      in_valid = 1'b0; wb_ready = 1'b1;
      tick();

      // async reset with a taken branch in flight
      wb_ready = 1'b0;
      send(16'h0, 3'd0, 0, 0, 4'h0, 1, 3'd3, 16'h00C0);
      chk("pre-rst taken", br_taken, 1);
      rst = 1'b1;
      #1;
      chk("arst wb_valid", wb_valid, 0);
      chk("arst br_taken", br_taken, 0);
      chk("arst flags", flags, 0);
      chk("arst retire", retire_cnt, 0);
      tick();
      rst = 1'b0;
      wb_ready = 1'b1;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         in_valid     = ($urandom_range(0, 9) < 7);
         wb_ready     = ($urandom_range(0, 9) < 6);
         in_result    = 16'($urandom);
         in_cond      = 4'($urandom);
         in_rd        = 3'($urandom);
         in_wr_en     = 1'($urandom);
         in_set_cc    = 1'($urandom);
         in_is_branch = ($urandom_range(0, 9) < 3);
         in_br_cond   = 3'($urandom);
         in_br_target = 16'($urandom);
         tick();
      end

      // retire counter wrap
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b1; wb_ready = 1'b1;
      in_is_branch = 1'b0; in_set_cc = 1'b0;
      for (int i = 0; i < 65536; i++) tick();
      chk("cnt max", retire_cnt, 16'hFFFF);
      in_valid = 1'b0;
      tick();
      chk("cnt wrap", retire_cnt, 0);
      chk("wrap empty", wb_valid, 0);

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
